hazard_unit: RTL and testbench
==============================

// Module: hazard_unit
// PURPOSE
//  Pipeline control for the kianv 5-stage core: drives StallF/StallD/Stall (ID/EX enable) and FlushD/FlushE,
//  plus the E-stage and D-stage forwarding selects consumed by the fetch, decode and execute stages.
//  Owns the sequential pipeline control: post-reset flush counter, load-use bubble, memory wait-state FSM
//  with timeout, and deferral of branch/jump redirects while the memory stage is frozen.
// PARAMETERS
//  RESET_FLUSH_CYCLES  2   cycles FlushD/FlushE are held after rst deasserts (1..15)
//  MEM_TIMEOUT         0   max WAIT cycles before bus_err; 0 = never time out
//  CNT_W               8   width of wait counter; must hold MEM_TIMEOUT
// PORTS
//  clk          in   1   core clock
//  rst          in   1   synchronous reset, active-high
//  Rs1D,Rs2D    in   5   source regs in D
//  Rs1E,Rs2E    in   5   source regs in E
//  RdE,RdM,RdW  in   5   dest regs in E/M/W
//  RegWriteE/M/W in  1   dest write enables per stage
//  LoadE        in   1   instruction in E is a load (ResultSrcE selects memory)
//  PCSrcE       in   1   taken branch or jump resolved in E
//  MemAccessM   in   1   load/store present in M
//  mem_ready    in   1   data-bus completion for current M access
//  mem_valid    out  1   data-bus request
//  bus_err      out  1   one-cycle pulse on memory timeout
//  StallF,StallD out 1   hold PC / IF-ID register
//  Stall        out  1   hold ID/EX register (decode stage enable = !Stall)
//  StallM       out  1   hold EX/MEM and MEM/WB registers
//  FlushD,FlushE out 1   clear IF-ID / ID-EX registers (bubble)
//  ForwardAE,ForwardBE out 2  ALU operand select: 00 regfile, 01 ResultW, 10 ALUResultM
//  ForwardAD,ForwardBD out 1  D-stage bypass: 1 = ResultW
// BEHAVIOUR
//  - Reset: all stalls 0, FlushD=FlushE=1, forwards 0, mem_valid=0, bus_err=0, FSM=M_IDLE, counters cleared.
//  - Flush counter loads RESET_FLUSH_CYCLES in rst; FlushD/FlushE forced 1 while nonzero, decrements each cycle;
//    no stall asserted while counting. Reset mid-operation aborts WAIT, drops mem_valid same cycle.
//  - Forwarding (E): M has priority over W; match requires RegWrite of that stage, Rd!=0, Rd==Rs. x0 never forwarded.
//  - Load-use: LoadE & RegWriteE & RdE!=0 & (RdE==Rs1D|RdE==Rs2D) -> StallF=StallD=1, FlushE=1, Stall=0.
//  - Memory FSM: M_IDLE, M_WAIT, M_ERR.
//    M_IDLE: mem_valid=MemAccessM; mem_ready same cycle -> stay, no stall (zero-wait access);
//            MemAccessM & !mem_ready -> M_WAIT, counter=1, memory stall this cycle.
//    M_WAIT: mem_valid=1, memory stall; mem_ready -> M_IDLE (stall drops same cycle);
//            counter==MEM_TIMEOUT (MEM_TIMEOUT!=0) -> M_ERR. Counter saturates when MEM_TIMEOUT=0.
//    M_ERR:  one cycle: bus_err=1, mem_valid=0, no memory stall (access retires as complete) -> M_IDLE.
//  - Memory stall = StallF=StallD=Stall=StallM=1; dominates load-use (no FlushE) and PCSrcE.
//  - Redirect: PCSrcE & !memory stall -> FlushD=FlushE=1 same cycle; while memory stall, flush is withheld and
//    taken when stall releases (instruction is still in E, so PCSrcE is re-evaluated; no extra storage).
//  - Redirect + load-use same cycle: redirect wins; FlushD=FlushE=1, StallF=StallD=0.
// CONFIGURATION
//  HAZARD_DECODE_FWD_EN defined: ForwardAD/BD = RegWriteW & RdW!=0 & RdW==Rs1D/Rs2D (W->D bypass).
//  Undefined: ForwardAD=ForwardBD=0; a W-stage match in D instead stalls one cycle
//    (StallF=StallD=1, FlushE=1), lowest priority below memory stall and redirect.
// STRUCTURE
//  riscv_defines.svh: ForwardE_t (2-bit enum FWD_NONE/FWD_W/FWD_M), ForwardAD_t/ForwardBD_t,
//    MemState_t (M_IDLE/M_WAIT/M_ERR).
//  Sub-module fwd_select: one instance per E operand (Rs, RdM, RegWriteM, RdW, RegWriteW -> ForwardE_t).
//  Top holds FSM, wait counter, flush counter, priority logic.
// TESTING
//  rst 1 cycle, RESET_FLUSH_CYCLES=2 -> FlushD=FlushE=1 for 2 cycles after rst low, then 0.
//  RdM=5,RegWriteM=1,RdW=5,RegWriteW=1,Rs1E=5 -> ForwardAE=10; Rs2E=0,RdW=0 -> ForwardBE=00.
//  LoadE=1,RdE=7,Rs2D=7 -> StallF=StallD=1,FlushE=1,Stall=0 for exactly 1 cycle.
//  MemAccessM=1, mem_ready after 3 cycles -> mem_valid 4 cycles, all stalls 1 for 3 cycles, FSM back M_IDLE.
//  MEM_TIMEOUT=4, mem_ready=0 -> M_ERR after 4 WAIT cycles, bus_err pulse 1 cycle, stalls drop.
//  PCSrcE=1 during memory stall -> no flush; FlushD=FlushE=1 in first cycle stall is released.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// Shared types for the kianv hazard unit: forwarding selects, memory FSM states,
// and the register-match helper used by both forwarding and hazard detection.
package hazard_unit_pkg;
  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_W    = 2'b01,
    FWD_M    = 2'b10
  } ForwardE_t;

  typedef enum logic {
    FWD_D_RF = 1'b0,
    FWD_D_W  = 1'b1
  } ForwardD_t;

  typedef ForwardD_t ForwardAD_t;
  typedef ForwardD_t ForwardBD_t;

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_WAIT = 2'd1,
    M_ERR  = 2'd2
  } MemState_t;

  // x0 is hardwired zero, so a write to it never produces a dependency.
  function automatic logic regMatch(input logic we, input logic [REG_W-1:0] rd,
                                    input logic [REG_W-1:0] rs);
    return we && (rd != '0) && (rd == rs);
  endfunction
endpackage

// File: rtl/hazard_unit_if.sv
// Data-bus handshake between the hazard unit (master) and the data memory (slave).
interface hazard_unit_if;
  logic mem_valid;
  logic mem_ready;
  logic bus_err;

  modport master (output mem_valid, output bus_err, input mem_ready);
  modport slave  (input mem_valid, input bus_err, output mem_ready);
endinterface

// File: rtl/hazard_unit_fwd_select.sv
// E-stage operand forwarding select for one source register; M beats W.
module fwd_select
  import hazard_unit_pkg::*;
(
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rdM,
  input  logic             regWriteM,
  input  logic [REG_W-1:0] rdW,
  input  logic             regWriteW,
  output ForwardE_t        fwd
);
  always_comb begin
    fwd = FWD_NONE;
    if (regMatch(regWriteM, rdM, rs))      fwd = FWD_M;
    else if (regMatch(regWriteW, rdW, rs)) fwd = FWD_W;
  end
endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard/control unit: reset flush counter, load-use bubble, memory wait FSM
// with timeout, redirect deferral. Optional W->D bypass under HAZARD_DECODE_FWD_EN.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int RESET_FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT        = 0,
  parameter int CNT_W              = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] Rs1D,
  input  logic [REG_W-1:0] Rs2D,
  input  logic [REG_W-1:0] Rs1E,
  input  logic [REG_W-1:0] Rs2E,
  input  logic [REG_W-1:0] RdE,
  input  logic [REG_W-1:0] RdM,
  input  logic [REG_W-1:0] RdW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             LoadE,
  input  logic             PCSrcE,
  input  logic             MemAccessM,
  hazard_unit_if.master    bus,
  output logic             StallF,
  output logic             StallD,
  output logic             Stall,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output ForwardE_t        ForwardAE,
  output ForwardE_t        ForwardBE,
  output logic             ForwardAD,
  output logic             ForwardBD
);
  MemState_t        state;
  logic [CNT_W-1:0] waitCnt;
  logic [3:0]       flushCnt;
  logic             flushing, memReq, memStall, timeout;
  logic             luHaz, dHaz;
  logic [1:0]       wMatchD;
  ForwardE_t        fwdA, fwdB;

  fwd_select u_fwdA (.rs(Rs1E), .rdM(RdM), .regWriteM(RegWriteM), .rdW(RdW),
                     .regWriteW(RegWriteW), .fwd(fwdA));
  fwd_select u_fwdB (.rs(Rs2E), .rdM(RdM), .regWriteM(RegWriteM), .rdW(RdW),
                     .regWriteW(RegWriteW), .fwd(fwdB));

  assign ForwardAE = rst ? FWD_NONE : fwdA;
  assign ForwardBE = rst ? FWD_NONE : fwdB;

  assign flushing = (flushCnt != 4'd0);
  // The pipeline is being cleared, so nothing in M may start a bus access yet.
  assign memReq   = MemAccessM && !flushing;
  assign timeout  = (MEM_TIMEOUT != 0) && (waitCnt == CNT_W'(MEM_TIMEOUT));

  assign luHaz   = LoadE && (regMatch(RegWriteE, RdE, Rs1D) || regMatch(RegWriteE, RdE, Rs2D));
  assign wMatchD = {regMatch(RegWriteW, RdW, Rs2D), regMatch(RegWriteW, RdW, Rs1D)};

`ifdef HAZARD_DECODE_FWD_EN
  assign ForwardAD = !rst && wMatchD[0];
  assign ForwardBD = !rst && wMatchD[1];
  assign dHaz      = 1'b0;
`else
  assign ForwardAD = 1'b0;
  assign ForwardBD = 1'b0;
  assign dHaz      = |wMatchD;
`endif

  always_comb begin
    bus.mem_valid = 1'b0;
    bus.bus_err   = 1'b0;
    memStall      = 1'b0;
    if (!rst) begin
      unique case (state)
        M_IDLE: begin
          bus.mem_valid = memReq;
          memStall      = memReq && !bus.mem_ready;
        end
        M_WAIT: begin
          bus.mem_valid = 1'b1;
          memStall      = !bus.mem_ready;
        end
        M_ERR:   bus.bus_err = 1'b1;
        default: ;
      endcase
    end
  end

  // A redirect during a memory stall is simply not acted on; the branch is still
  // in E when the stall releases, so PCSrcE raises the flush then.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    Stall  = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (rst || flushing) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (memStall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      Stall  = 1'b1;
      StallM = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (luHaz || dHaz) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= M_IDLE;
      waitCnt  <= '0;
      flushCnt <= 4'(RESET_FLUSH_CYCLES);
    end else begin
      if (flushing) flushCnt <= flushCnt - 4'd1;
      unique case (state)
        M_IDLE: if (memReq && !bus.mem_ready) begin
          state   <= M_WAIT;
          waitCnt <= CNT_W'(1);
        end
        M_WAIT: begin
          if (bus.mem_ready) begin
            state   <= M_IDLE;
            waitCnt <= '0;
          end else if (timeout) begin
            state   <= M_ERR;
            waitCnt <= '0;
          end else if (waitCnt != '1) begin
            waitCnt <= waitCnt + CNT_W'(1);
          end
        end
        M_ERR:   state <= M_IDLE;
        default: state <= M_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit; expected output words queued by the driver, checked by a monitor.
module tb_hazard_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteE, RegWriteM, RegWriteW, LoadE, PCSrcE, MemAccessM;
  logic StallF, StallD, Stall, StallM, FlushD, FlushE, ForwardAD, ForwardBD;
  logic [1:0] ForwardAE, ForwardBE;

  hazard_unit_if bus();

  hazard_unit #(.RESET_FLUSH_CYCLES(2), .MEM_TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .LoadE(LoadE), .PCSrcE(PCSrcE), .MemAccessM(MemAccessM),
    .bus(bus),
    .StallF(StallF), .StallD(StallD), .Stall(Stall), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD)
  );

`ifdef HAZARD_DECODE_FWD_EN
  localparam bit DFWD = 1'b1;
`else
  localparam bit DFWD = 1'b0;
`endif

  typedef struct {
    logic [13:0] exp;
    string       name;
  } vec_t;

  vec_t sb[$];
  int   nVec = 0;
  int   nMis = 0;

  wire [13:0] got = {StallF, StallD, Stall, StallM, FlushD, FlushE, ForwardAE, ForwardBE,
                     ForwardAD, ForwardBD, bus.mem_valid, bus.bus_err};

  function automatic logic [13:0] ex(input bit sF, input bit sD, input bit sE, input bit sM,
                                     input bit fD, input bit fE, input bit [1:0] fa,
                                     input bit [1:0] fb, input bit ad, input bit bd,
                                     input bit mv, input bit be);
    return {sF, sD, sE, sM, fD, fE, fa, fb, ad, bd, mv, be};
  endfunction

  task automatic apply(input logic [13:0] e, input string n);
    vec_t v;
    v.exp  = e;
    v.name = n;
    sb.push_back(v);
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    LoadE = 0; PCSrcE = 0; MemAccessM = 0; bus.mem_ready = 0;
  endtask

  // Monitor: one vector per cycle, sampled mid-cycle.
  vec_t cur;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      nVec++;
      if (got !== cur.exp) begin
        nMis++;
        $display("FAIL %s: got %b want %b (sF sD s sM fD fE fa fb ad bd mv be)",
                 cur.name, got, cur.exp);
      end
    end
  end

  logic [13:0] Z, FL, MS;

  initial begin
    Z  = '0;
    FL = ex(0,0,0,0,1,1,2'd0,2'd0,0,0,0,0);
    MS = ex(1,1,1,1,0,0,2'd0,2'd0,0,0,1,0);
    clr();
    rst = 1'b1;
    MemAccessM = 1;
    @(posedge clk); #1;
    apply(FL, "reset_state");
    rst = 1'b0; MemAccessM = 0;
    apply(FL, "flush1");
    RegWriteW = 1; RdW = 3; Rs1D = 3;
    apply(ex(0,0,0,0,1,1,2'd0,2'd0,DFWD,0,0,0), "flush2_nostall");
    clr();
    apply(Z, "flush_done");

    RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5;
    apply(ex(0,0,0,0,0,0,2'b10,2'b00,0,0,0,0), "fwd_m_priority");
    Rs2E = 5; RegWriteM = 0;
    apply(ex(0,0,0,0,0,0,2'b01,2'b01,0,0,0,0), "fwd_w");
    RdM = 0; RdW = 0; RegWriteM = 1; Rs1E = 0; Rs2E = 0;
    apply(Z, "fwd_x0");

    clr();
    LoadE = 1; RegWriteE = 1; RdE = 7; Rs2D = 7;
    apply(ex(1,1,0,0,0,1,2'd0,2'd0,0,0,0,0), "load_use");
    LoadE = 0; RegWriteE = 0; RdE = 0;
    apply(Z, "load_use_release");
    LoadE = 1; RegWriteE = 1; RdE = 7; PCSrcE = 1;
    apply(FL, "redirect_over_load_use");

    clr();
    MemAccessM = 1;
    apply(MS, "mem_wait0");
    PCSrcE = 1;
    apply(MS, "mem_wait1_redir_held");
    apply(MS, "mem_wait2_redir_held");
    bus.mem_ready = 1;
    apply(ex(0,0,0,0,1,1,2'd0,2'd0,0,0,1,0), "mem_release_redirect");
    clr();
    apply(Z, "mem_back_idle");
    MemAccessM = 1; bus.mem_ready = 1;
    apply(ex(0,0,0,0,0,0,2'd0,2'd0,0,0,1,0), "mem_zero_wait");
    clr();
    apply(Z, "zero_wait_idle");

    MemAccessM = 1;
    apply(MS, "timeout_idle");
    for (int i = 1; i <= 4; i++) apply(MS, $sformatf("timeout_wait%0d", i));
    apply(ex(0,0,0,0,0,0,2'd0,2'd0,0,0,0,1), "timeout_bus_err");
    clr();
    apply(Z, "timeout_done");

    MemAccessM = 1;
    apply(MS, "rstmid_idle");
    apply(MS, "rstmid_wait");
    rst = 1'b1;
    apply(FL, "rstmid_reset");
    rst = 1'b0; MemAccessM = 0;
    apply(FL, "rstmid_flush1");
    apply(FL, "rstmid_flush2");
    apply(Z, "rstmid_idle_after");

    RegWriteW = 1; RdW = 9; Rs1D = 9;
    apply(ex(!DFWD,!DFWD,0,0,0,!DFWD,2'd0,2'd0,DFWD,0,0,0), "w_in_d_rs1");
    Rs1D = 0; Rs2D = 9;
    apply(ex(!DFWD,!DFWD,0,0,0,!DFWD,2'd0,2'd0,0,DFWD,0,0), "w_in_d_rs2");
    clr();

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      nMis++;
      $display("FAIL drain: %0d vectors unchecked, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end
endmodule
